// File: rtl/req_arbiter.sv
// Request front end for the 4-to-2 encoder: sync, debounce, rising-edge capture, round-robin one-hot grant.
// Build option: define REQ_DEBOUNCE_EN to include the per-line debounce filter.
module req_arbiter #(
  parameter int DB_CYCLES = 8,
  parameter int DB_W      = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic [3:0] REQ,
  output logic [3:0] Y,
  output logic       Y_VALID,
  input  logic       Y_READY,
  output logic [3:0] PEND,
  output logic       OVR,
  input  logic       OVR_CLR
);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] grant_idx;

  logic [3:0] s_meta;
  logic [3:0] s_sync;
  logic [3:0] filt;
  logic [3:0] filt_d;
  logic [3:0] rise;
  logic [3:0] hs_clr;
  logic [3:0] ovr_hit;

  logic [1:0] pick;
  logic       pick_ok;
  logic [1:0] cand;

  // NOTE: sequential state always uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_meta <= '0;
      s_sync <= '0;
    end else begin
      s_meta <= REQ;
      s_sync <= s_meta;
    end
  end

`ifdef REQ_DEBOUNCE_EN
  // DB_W must be wide enough to hold DB_CYCLES-1.
  logic [DB_W-1:0] cnt [4];
  logic [3:0]      filt_q;

  // NOTE: the counter array is a bank of flops, not RAM, so it is cleared by
  // the async reset along with the rest of the state.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_q <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (s_sync[i] == filt_q[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_W'(DB_CYCLES - 1)) begin
          filt_q[i] <= s_sync[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign filt = filt_q;
`else
  // Filter parameters have no effect in this build.
  if (DB_CYCLES < 0 && DB_W < 0) begin : g_db_unused
  end

  assign filt = s_sync;
`endif

  assign rise    = filt & ~filt_d;
  assign hs_clr  = (Y_VALID && Y_READY) ? Y : 4'b0000;
  // A rise on a line whose previous event is still pending and not leaving now is lost.
  assign ovr_hit = rise & PEND & ~hs_clr;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      filt_d <= '0;
      PEND   <= '0;
      OVR    <= 1'b0;
    end else begin
      filt_d <= filt;
      PEND   <= rise | (PEND & ~hs_clr);
      if (|ovr_hit) begin
        OVR <= 1'b1;
      end else if (OVR_CLR) begin
        OVR <= 1'b0;
      end
    end
  end

  // NOTE: every variable gets a default before the loop so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    pick    = 2'd0;
    pick_ok = 1'b0;
    cand    = 2'd0;
    // Scan from the far end so the candidate closest to ptr is written last.
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (PEND[cand]) begin
        pick    = cand;
        pick_ok = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      ptr       <= 2'd0;
      grant_idx <= 2'd0;
      Y         <= 4'b0000;
      Y_VALID   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_ok) begin
            Y         <= 4'b0001 << pick;
            Y_VALID   <= 1'b1;
            grant_idx <= pick;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (Y_READY) begin
            ptr     <= grant_idx + 2'd1;
            Y       <= 4'b0000;
            Y_VALID <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_req_arbiter.sv
// Directed bench for req_arbiter: a table of {inputs, hold cycles, expected outputs}
// plus hand-written reset, glitch and reset-mid-operation sequences.
module tb_req_arbiter;

  localparam int DB = 8;
`ifdef REQ_DEBOUNCE_EN
  localparam int L = DB;
`else
  localparam int L = 0;
`endif

  logic       CLK = 1'b0;
  logic       RST_N;
  logic [3:0] REQ;
  logic [3:0] Y;
  logic       Y_VALID;
  logic       Y_READY;
  logic [3:0] PEND;
  logic       OVR;
  logic       OVR_CLR;

  int n_vec = 0;
  int n_bad = 0;

  req_arbiter #(.DB_CYCLES(DB), .DB_W(4)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .REQ    (REQ),
    .Y      (Y),
    .Y_VALID(Y_VALID),
    .Y_READY(Y_READY),
    .PEND   (PEND),
    .OVR    (OVR),
    .OVR_CLR(OVR_CLR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] req;
    logic       rdy;
    logic       oclr;
    int         n;
    bit         every;
    logic [3:0] y;
    logic       v;
    logic [3:0] pend;
    logic       ovr;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic [3:0] req, input logic rdy, input logic oclr,
                              input int n, input bit every, input logic [3:0] y,
                              input logic v, input logic [3:0] pend, input logic ovr);
    vec_t r;
    r.req = req; r.rdy = rdy; r.oclr = oclr; r.n = n; r.every = every;
    r.y = y; r.v = v; r.pend = pend; r.ovr = ovr;
    tbl.push_back(r);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [3:0] y, input logic v,
                           input logic [3:0] pend, input logic ovr);
    check({tag, " Y"}, Y, y);
    check({tag, " Y_VALID"}, {3'b000, Y_VALID}, {3'b000, v});
    check({tag, " PEND"}, PEND, pend);
    check({tag, " OVR"}, {3'b000, OVR}, {3'b000, ovr});
  endtask

  initial begin
    // Reset release with all lines high: four grants in order, one cycle each.
    add(4'b1111, 1, 0, 2+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0000, 0, 4'b1111, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0001, 1, 4'b1111, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0000, 0, 4'b1110, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0010, 1, 4'b1110, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0000, 0, 4'b1100, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0100, 1, 4'b1100, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0000, 0, 4'b1000, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b1000, 1, 4'b1000, 0);
    add(4'b1111, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);
    // Wrap after line 3: lines 0 and 3 pending -> line 0, then line 3.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b1001, 0, 0, 3+L, 0, 4'b0000, 0, 4'b1001, 0);
    add(4'b1001, 0, 0, 1,   0, 4'b0001, 1, 4'b1001, 0);
    add(4'b1001, 0, 0, 5,   1, 4'b0001, 1, 4'b1001, 0);
    add(4'b1001, 1, 0, 1,   0, 4'b0000, 0, 4'b1000, 0);
    add(4'b1001, 0, 0, 1,   0, 4'b1000, 1, 4'b1000, 0);
    add(4'b1001, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);
    // Backpressure: line 0 held for 20 cycles, line 1 two cycles after ready.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b0011, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0011, 0);
    add(4'b0011, 0, 0, 1,   0, 4'b0001, 1, 4'b0011, 0);
    add(4'b0011, 0, 0, 20,  1, 4'b0001, 1, 4'b0011, 0);
    add(4'b0011, 1, 0, 1,   0, 4'b0000, 0, 4'b0010, 0);
    add(4'b0011, 1, 0, 1,   0, 4'b0010, 1, 4'b0010, 0);
    add(4'b0011, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);
    // Single-line latency, then wrap after line 2 with lines 0 and 3 pending.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b0100, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0100, 0);
    add(4'b0100, 0, 0, 1,   0, 4'b0100, 1, 4'b0100, 0);
    add(4'b1101, 0, 0, 3+L, 0, 4'b0100, 1, 4'b1101, 0);
    add(4'b1101, 1, 0, 1,   0, 4'b0000, 0, 4'b1001, 0);
    add(4'b1101, 0, 0, 1,   0, 4'b1000, 1, 4'b1001, 0);
    add(4'b1101, 1, 0, 1,   0, 4'b0000, 0, 4'b0001, 0);
    add(4'b1101, 1, 0, 1,   0, 4'b0001, 1, 4'b0001, 0);
    add(4'b1101, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);
    // Overrun on line 2, sticky, then cleared.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b0100, 0, 0, 4+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0000, 0, 0, 3+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 0, 0, 2+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 0, 0, 1,   0, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 0, 0, 3,   1, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 0, 1, 1,   0, 4'b0100, 1, 4'b0100, 0);
    // Rise coinciding with the handshake of the same line: set wins, no overrun.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 0, 0, 2+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 1, 0, 1,   0, 4'b0000, 0, 4'b0100, 0);
    add(4'b0100, 0, 0, 1,   0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);
    // Overrun and OVR_CLR in the same cycle: overrun wins.
    add(4'b0000, 0, 0, 3+L, 0, 4'b0000, 0, 4'b0000, 0);
    add(4'b0100, 0, 0, 4+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0000, 0, 0, 3+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 0, 0, 2+L, 0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 0, 1, 1,   0, 4'b0100, 1, 4'b0100, 1);
    add(4'b0100, 0, 1, 1,   0, 4'b0100, 1, 4'b0100, 0);
    add(4'b0100, 1, 0, 1,   0, 4'b0000, 0, 4'b0000, 0);

    RST_N   = 1'b0;
    REQ     = 4'b1111;
    Y_READY = 1'b0;
    OVR_CLR = 1'b0;
    tick(3);
    check_all("reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    RST_N = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      REQ     = tbl[i].req;
      Y_READY = tbl[i].rdy;
      OVR_CLR = tbl[i].oclr;
      if (tbl[i].every) begin
        for (int c = 0; c < tbl[i].n; c++) begin
          tick(1);
          check_all($sformatf("row%0d c%0d", i, c), tbl[i].y, tbl[i].v, tbl[i].pend, tbl[i].ovr);
        end
      end else begin
        tick(tbl[i].n);
        check_all($sformatf("row%0d", i), tbl[i].y, tbl[i].v, tbl[i].pend, tbl[i].ovr);
      end
    end
    Y_READY = 1'b0;
    OVR_CLR = 1'b0;

`ifdef REQ_DEBOUNCE_EN
    // Pulses of 5 and DB-1 cycles on line 1 are rejected; a DB-cycle pulse is accepted.
    REQ = 4'b0110; tick(5);
    REQ = 4'b0100; tick(3+L+2);
    check_all("glitch5", 4'b0000, 1'b0, 4'b0000, 1'b0);
    REQ = 4'b0110; tick(DB-1);
    REQ = 4'b0100; tick(3+L+2);
    check_all("glitch_db-1", 4'b0000, 1'b0, 4'b0000, 1'b0);
    REQ = 4'b0110; tick(DB);
    REQ = 4'b0100; tick(3);
    check_all("pulse_db pend", 4'b0000, 1'b0, 4'b0010, 1'b0);
    tick(1);
    check_all("pulse_db grant", 4'b0010, 1'b1, 4'b0010, 1'b0);
`else
    // One-cycle pulse captured by the synchronizer produces a grant.
    REQ = 4'b0110; tick(1);
    REQ = 4'b0100; tick(2);
    check_all("pulse1 pend", 4'b0000, 1'b0, 4'b0010, 1'b0);
    tick(1);
    check_all("pulse1 grant", 4'b0010, 1'b1, 4'b0010, 1'b0);
`endif
    Y_READY = 1'b1; tick(1);
    check_all("pulse accept", 4'b0000, 1'b0, 4'b0000, 1'b0);
    Y_READY = 1'b0; tick(3+L);

    // Rises on lines 0,1,3 with ptr at 2: line 3 offered, then reset mid-offer.
    REQ = 4'b1111; tick(4+L);
    check_all("pre-reset offer", 4'b1000, 1'b1, 4'b1011, 1'b0);
    RST_N = 1'b0;
    #1;
    check_all("async reset", 4'b0000, 1'b0, 4'b0000, 1'b0);
    tick(2);
    RST_N = 1'b1;
    tick(3+L);
    check_all("re-release pend", 4'b0000, 1'b0, 4'b1111, 1'b0);
    tick(1);
    check_all("re-release grant", 4'b0001, 1'b1, 4'b1111, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
